// File: rtl/axi4ar_arbiter.sv
// axi4ar_arbiter: two-requester AXI4 AR-channel arbiter with round-robin/QoS
// selection and a single registered output stage; arid[1] carries the winner.
module axi4ar_arbiter #(
    parameter int RST_PTR = 0,
    parameter int QOS_ARB = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s0_arvalid,
    output logic        s0_arready,
    input  logic [1:0]  s0_arid,
    input  logic [31:0] s0_araddr,
    input  logic [7:0]  s0_arlen,
    input  logic [2:0]  s0_arsize,
    input  logic [1:0]  s0_arburst,
    input  logic        s0_arlock,
    input  logic [3:0]  s0_arcache,
    input  logic [2:0]  s0_arprot,
    input  logic [3:0]  s0_arqos,
    input  logic [3:0]  s0_arregion,
    input  logic        s1_arvalid,
    output logic        s1_arready,
    input  logic [1:0]  s1_arid,
    input  logic [31:0] s1_araddr,
    input  logic [7:0]  s1_arlen,
    input  logic [2:0]  s1_arsize,
    input  logic [1:0]  s1_arburst,
    input  logic        s1_arlock,
    input  logic [3:0]  s1_arcache,
    input  logic [2:0]  s1_arprot,
    input  logic [3:0]  s1_arqos,
    input  logic [3:0]  s1_arregion,
    output logic        m_arvalid,
    input  logic        m_arready,
    output logic [1:0]  m_arid,
    output logic [31:0] m_araddr,
    output logic [7:0]  m_arlen,
    output logic [2:0]  m_arsize,
    output logic [1:0]  m_arburst,
    output logic        m_arlock,
    output logic [3:0]  m_arcache,
    output logic [2:0]  m_arprot,
    output logic [3:0]  m_arqos,
    output logic [3:0]  m_arregion,
    output logic        grant_idx
);
    typedef enum logic {EMPTY, FULL} state_e;

    state_e      state_q, state_d;
    logic        ptr_q, ptr_d, grant_q, grant_d;
    logic [62:0] pl_q, pl_d, s0_pl, s1_pl;
    logic        free, win, acc;

    // arid[1] is replaced by the requester index so read data can be routed back
    assign s0_pl = {1'b0, s0_arid[0], s0_araddr, s0_arlen, s0_arsize, s0_arburst,
                    s0_arlock, s0_arcache, s0_arprot, s0_arqos, s0_arregion};
    assign s1_pl = {1'b1, s1_arid[0], s1_araddr, s1_arlen, s1_arsize, s1_arburst,
                    s1_arlock, s1_arcache, s1_arprot, s1_arqos, s1_arregion};

    assign {m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock,
            m_arcache, m_arprot, m_arqos, m_arregion} = pl_q;
    assign m_arvalid = (state_q == FULL);
    assign grant_idx = grant_q;

    always_comb begin
        free       = (state_q == EMPTY) | m_arready;
        win        = (s0_arvalid & s1_arvalid)
                   ? ((QOS_ARB != 0 && s0_arqos != s1_arqos) ? (s1_arqos > s0_arqos) : ptr_q)
                   : s1_arvalid;
        s0_arready = rst_n & free & s0_arvalid & ~win;
        s1_arready = rst_n & free & s1_arvalid & win;
        acc        = s0_arready | s1_arready;
        state_d    = acc ? FULL : (m_arready ? EMPTY : state_q);
        ptr_d      = acc ? ~win : ptr_q;
        grant_d    = acc ? win : grant_q;
        pl_d       = acc ? (win ? s1_pl : s0_pl) : pl_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ptr_q   <= 1'(RST_PTR);
            grant_q <= 1'b0;
            pl_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            pl_q    <= pl_d;
        end
    end
endmodule

// File: tb/tb_axi4ar_arbiter.sv
// tb_axi4ar_arbiter: directed vectors for the AR arbiter; instance a is pure
// round-robin, instance b has QoS arbitration, both driven by the same stimulus.
module tb_axi4ar_arbiter;
    logic        clk = 1'b0, rst_n = 1'b0, m_arready = 1'b0;
    logic        s0_arvalid = 1'b0, s1_arvalid = 1'b0;
    logic [1:0]  s0_arid = '0, s1_arid = '0;
    logic [31:0] s0_araddr = '0, s1_araddr = '0;
    logic [7:0]  s0_arlen = 8'd3, s1_arlen = 8'd7;
    logic [2:0]  s0_arsize = 3'd2, s1_arsize = 3'd3;
    logic [1:0]  s0_arburst = 2'd1, s1_arburst = 2'd2;
    logic        s0_arlock = 1'b0, s1_arlock = 1'b1;
    logic [3:0]  s0_arcache = 4'h3, s1_arcache = 4'hA;
    logic [2:0]  s0_arprot = 3'd1, s1_arprot = 3'd5;
    logic [3:0]  s0_arqos = '0, s1_arqos = '0;
    logic [3:0]  s0_arregion = 4'h1, s1_arregion = 4'hC;

    logic        a_s0rdy, a_s1rdy, a_mv, a_lock, a_g;
    logic [1:0]  a_id, a_burst;
    logic [31:0] a_addr;
    logic [7:0]  a_len;
    logic [2:0]  a_size, a_prot;
    logic [3:0]  a_cache, a_qos, a_region;
    logic        b_s0rdy, b_s1rdy, b_mv, b_lock, b_g;
    logic [1:0]  b_id, b_burst;
    logic [31:0] b_addr;
    logic [7:0]  b_len;
    logic [2:0]  b_size, b_prot;
    logic [3:0]  b_cache, b_qos, b_region;

    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    axi4ar_arbiter #(.RST_PTR(0), .QOS_ARB(0)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .s0_arvalid(s0_arvalid), .s0_arready(a_s0rdy), .s0_arid(s0_arid), .s0_araddr(s0_araddr),
        .s0_arlen(s0_arlen), .s0_arsize(s0_arsize), .s0_arburst(s0_arburst), .s0_arlock(s0_arlock),
        .s0_arcache(s0_arcache), .s0_arprot(s0_arprot), .s0_arqos(s0_arqos), .s0_arregion(s0_arregion),
        .s1_arvalid(s1_arvalid), .s1_arready(a_s1rdy), .s1_arid(s1_arid), .s1_araddr(s1_araddr),
        .s1_arlen(s1_arlen), .s1_arsize(s1_arsize), .s1_arburst(s1_arburst), .s1_arlock(s1_arlock),
        .s1_arcache(s1_arcache), .s1_arprot(s1_arprot), .s1_arqos(s1_arqos), .s1_arregion(s1_arregion),
        .m_arvalid(a_mv), .m_arready(m_arready), .m_arid(a_id), .m_araddr(a_addr), .m_arlen(a_len),
        .m_arsize(a_size), .m_arburst(a_burst), .m_arlock(a_lock), .m_arcache(a_cache),
        .m_arprot(a_prot), .m_arqos(a_qos), .m_arregion(a_region), .grant_idx(a_g)
    );

    axi4ar_arbiter #(.RST_PTR(0), .QOS_ARB(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .s0_arvalid(s0_arvalid), .s0_arready(b_s0rdy), .s0_arid(s0_arid), .s0_araddr(s0_araddr),
        .s0_arlen(s0_arlen), .s0_arsize(s0_arsize), .s0_arburst(s0_arburst), .s0_arlock(s0_arlock),
        .s0_arcache(s0_arcache), .s0_arprot(s0_arprot), .s0_arqos(s0_arqos), .s0_arregion(s0_arregion),
        .s1_arvalid(s1_arvalid), .s1_arready(b_s1rdy), .s1_arid(s1_arid), .s1_araddr(s1_araddr),
        .s1_arlen(s1_arlen), .s1_arsize(s1_arsize), .s1_arburst(s1_arburst), .s1_arlock(s1_arlock),
        .s1_arcache(s1_arcache), .s1_arprot(s1_arprot), .s1_arqos(s1_arqos), .s1_arregion(s1_arregion),
        .m_arvalid(b_mv), .m_arready(m_arready), .m_arid(b_id), .m_araddr(b_addr), .m_arlen(b_len),
        .m_arsize(b_size), .m_arburst(b_burst), .m_arlock(b_lock), .m_arcache(b_cache),
        .m_arprot(b_prot), .m_arqos(b_qos), .m_arregion(b_region), .grant_idx(b_g)
    );

    typedef struct {
        logic        s0v, s1v;
        logic [1:0]  s0id, s1id;
        logic [31:0] s0a, s1a;
        logic        mr;
        logic        e0, e1, emv, eg;
        logic [31:0] ea;
        logic [1:0]  eid;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 2'b01, 2'b10, 32'h2000, 32'h3000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h2000, 2'b01};
        vecs[1]  = '{1'b1, 1'b1, 2'b01, 2'b10, 32'h2000, 32'h3000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h3000, 2'b10};
        vecs[2]  = '{1'b1, 1'b1, 2'b01, 2'b10, 32'h2000, 32'h3000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h2000, 2'b01};
        vecs[3]  = '{1'b1, 1'b1, 2'b01, 2'b10, 32'h2000, 32'h3000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h3000, 2'b10};
        vecs[4]  = '{1'b0, 1'b0, 2'b00, 2'b00, 32'h0,    32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3000, 2'b10};
        vecs[5]  = '{1'b1, 1'b0, 2'b01, 2'b00, 32'h1000, 32'h0,    1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1000, 2'b01};
        vecs[6]  = '{1'b0, 1'b1, 2'b00, 2'b11, 32'h0, 32'h8000_0040, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1000, 2'b01};
        vecs[7]  = '{1'b0, 1'b1, 2'b00, 2'b11, 32'h0, 32'h8000_0040, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h8000_0040, 2'b11};
        vecs[8]  = '{1'b0, 1'b0, 2'b00, 2'b00, 32'h0,    32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0040, 2'b11};
        vecs[9]  = '{1'b0, 1'b1, 2'b00, 2'b10, 32'h0,    32'h4000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h4000, 2'b10};
        vecs[10] = '{1'b1, 1'b0, 2'b11, 2'b00, 32'h5000, 32'h0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h4000, 2'b10};

        // reset state, with a request pending that must not be acknowledged
        s0_arvalid = 1'b1;
        #2;
        chk("rst_mvalid", 32'(a_mv), 0);
        chk("rst_grant", 32'(a_g), 0);
        chk("rst_addr", a_addr, 0);
        chk("rst_s0rdy", 32'(a_s0rdy), 0);
        step();
        step();
        s0_arvalid = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            s0_arvalid = vecs[i].s0v; s1_arvalid = vecs[i].s1v;
            s0_arid = vecs[i].s0id;   s1_arid = vecs[i].s1id;
            s0_araddr = vecs[i].s0a;  s1_araddr = vecs[i].s1a;
            m_arready = vecs[i].mr;
            #1;
            chk($sformatf("v%0d_s0rdy", i), 32'(a_s0rdy), 32'(vecs[i].e0));
            chk($sformatf("v%0d_s1rdy", i), 32'(a_s1rdy), 32'(vecs[i].e1));
            step();
            chk($sformatf("v%0d_mvalid", i), 32'(a_mv), 32'(vecs[i].emv));
            chk($sformatf("v%0d_grant", i), 32'(a_g), 32'(vecs[i].eg));
            chk($sformatf("v%0d_addr", i), a_addr, vecs[i].ea);
            chk($sformatf("v%0d_id", i), 32'(a_id), 32'(vecs[i].eid));
        end

        // backpressure: s1 beat held for 5 stalled cycles while both requesters wait
        s0_arvalid = 1'b0; s1_arvalid = 1'b1; s1_arid = 2'b10; s1_araddr = 32'h8000_0040;
        m_arready = 1'b1;
        step();
        s0_arvalid = 1'b1; s0_araddr = 32'h6000; s0_arid = 2'b00;
        s1_araddr = 32'h9000; m_arready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_s0rdy", 32'(a_s0rdy), 0);
            chk("bp_s1rdy", 32'(a_s1rdy), 0);
            chk("bp_mvalid", 32'(a_mv), 1);
            chk("bp_addr", a_addr, 32'h8000_0040);
            chk("bp_id", 32'(a_id), 32'(2'b10));
            chk("bp_len", 32'(a_len), 7);
            chk("bp_cache", 32'(a_cache), 32'hA);
            chk("bp_region", 32'(a_region), 32'hC);
            step();
        end
        s1_arvalid = 1'b0; m_arready = 1'b1;
        #1;
        chk("bp_rel_s0rdy", 32'(a_s0rdy), 1);
        step();
        chk("bp_next_addr", a_addr, 32'h6000);
        chk("bp_next_grant", 32'(a_g), 0);

        // reset while FULL and stalled: output clears without waiting for a clock
        m_arready = 1'b0; s0_arvalid = 1'b0;
        step();
        chk("pre_rst_mvalid", 32'(a_mv), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_mvalid", 32'(a_mv), 0);
        chk("arst_addr", a_addr, 0);
        chk("arst_id", 32'(a_id), 0);
        step();
        rst_n = 1'b1;
        s0_arvalid = 1'b1; s1_arvalid = 1'b1; m_arready = 1'b1;
        s0_araddr = 32'h7000; s1_araddr = 32'h7100;
        #1;
        chk("post_rst_s0rdy", 32'(a_s0rdy), 1);
        chk("post_rst_s1rdy", 32'(a_s1rdy), 0);
        step();
        chk("post_rst_grant", 32'(a_g), 0);

        // QoS arbitration on instance b, pointer at 0 after a fresh reset
        s0_arvalid = 1'b0; s1_arvalid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        s0_arvalid = 1'b1; s1_arvalid = 1'b1; s0_arqos = 4'd2; s1_arqos = 4'd9;
        #1;
        chk("qos_b_s1rdy", 32'(b_s1rdy), 1);
        chk("qos_a_s0rdy", 32'(a_s0rdy), 1);
        step();
        chk("qos_grant1", 32'(b_g), 1);
        chk("qos_qos1", 32'(b_qos), 9);
        s1_arvalid = 1'b0;
        step();
        chk("qos_grant2", 32'(b_g), 0);
        s1_arvalid = 1'b1; s0_arqos = 4'd5; s1_arqos = 4'd5;
        step();
        chk("qos_tie1", 32'(b_g), 1);
        step();
        chk("qos_tie2", 32'(b_g), 0);
        s0_arvalid = 1'b0; s1_arvalid = 1'b0;
        step();
        chk("drain_mvalid", 32'(b_mv), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/axi4ar_arbiter.md
Name: axi4ar_arbiter

Overview:
- Two-requester arbiter for the AXI4 read-address (AR) channel.
- Merges requester 0 (instruction fetch) and requester 1 (load/store) onto one AR master port toward the interconnect or memory model.
- Round-robin arbitration, optional QoS priority, one registered output stage.
- Rewrites arid[1] with the winning requester index so the R-channel router can steer read data back.

Parameters:
- RST_PTR, 0: requester holding priority after reset (0 or 1).
- QOS_ARB, 0: 1 = higher arqos wins outright; ties fall back to round-robin. 0 = pure round-robin.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s0_arvalid  in  1  requester 0 AR valid.
- s0_arready  out  1  requester 0 AR ready.
- s0_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arqos/arregion  in  2/32/8/3/2/1/4/3/4/4  requester 0 AR payload.
- s1_arvalid  in  1  requester 1 AR valid.
- s1_arready  out  1  requester 1 AR ready.
- s1_arid/.../arregion  in  same widths as s0  requester 1 AR payload.
- m_arvalid  out  1  master AR valid.
- m_arready  in  1  master AR ready.
- m_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arqos/arregion  out  same widths  registered AR payload.
- grant_idx  out  1  requester index of the beat currently held in the output register.

Behaviour:
- Reset (async assert, sync-safe deassert): m_arvalid=0, all m_* payload=0, grant_idx=0, s0_arready=s1_arready=0, state=EMPTY, priority pointer=RST_PTR.
- Output register states:
  - EMPTY: m_arvalid=0.
  - FULL: m_arvalid=1.
- Register free: free = (state==EMPTY) | m_arready.
- Winner (combinational):
  - Only one sN_arvalid high: that N wins.
  - Both high and QOS_ARB=1 with differing arqos: larger arqos wins.
  - Otherwise: the requester named by the pointer wins.
- sN_arready = free & sN_arvalid & (N==winner). The loser sees arready=0. Never both high.
- Accept on sN_arvalid & sN_arready:
  - Next edge: load payload; m_arid = {N, sN_arid[0]}; grant_idx=N; state=FULL.
  - Pointer moves to the other requester. The pointer updates only on accept.
- Transitions:
  - FULL with m_arready=1 and no accept: state=EMPTY, m_arvalid=0.
  - FULL with m_arready=1 and a simultaneous accept: stays FULL with the new payload. Back-to-back throughput is 1 beat per cycle.
  - FULL with m_arready=0: payload and m_arvalid held stable (AXI rule). sN_arready=0.
- Latency: sN handshake at edge k -> m_arvalid at edge k+1. Minimum 1 cycle.
- Requester sN_arvalid may rise while arready=0. It must stay asserted (AXI), and the arbiter grants it when free and winning. No combinational path from m_arready to m_arvalid.
- Starvation bound: with QOS_ARB=0, a continuously valid requester is granted within 2 accepts.
- arlock, arcache, arprot, arqos, arregion, arlen, arsize, arburst, araddr pass through unchanged. No burst legality checks.
- Reset mid-transfer: a pending beat is dropped, m_arvalid falls immediately, pointer returns to RST_PTR.

Test Plan:
- Single request:
  - Stimulus: s0 only, araddr=0x0000_1000, arid=2'b01, arlen=3, m_arready=1.
  - Required: s0_arready=1 same cycle; next cycle m_arvalid=1, m_araddr=0x1000, m_arid=2'b01, grant_idx=0.
- Contention round-robin:
  - Stimulus: s0 and s1 valid continuously for 4 beats, RST_PTR=0, m_arready=1.
  - Required: grants 0,1,0,1; m_arid[1] sequence 0,1,0,1; one beat per cycle.
- Backpressure:
  - Stimulus: s1 beat araddr=0x8000_0040 accepted, then m_arready=0 for 5 cycles.
  - Required: m_arvalid and all payload stable 5 cycles; s0/s1_arready=0 throughout; beat completes on first m_arready=1.
- QoS priority:
  - Stimulus: QOS_ARB=1, s0 arqos=2, s1 arqos=9, both valid, pointer=0.
  - Required: s1 granted first, then s0. With equal arqos=5, grant follows the pointer.
- Reset mid-operation:
  - Stimulus: rst_n low while FULL with m_arready=0.
  - Required: m_arvalid=0 asynchronously and payload=0; after release, first contended grant goes to RST_PTR.
- ID rewrite:
  - Stimulus: s1_arid=2'b10.
  - Required: m_arid=2'b10. With s1_arid=2'b11, m_arid=2'b11 (bit1 forced to requester index 1, bit0 passed).
